// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data SRAM between the data-memory port (D, read/write)
// and the instruction-fetch port (I, read-only), routing each read response back.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_wen,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       resp_vld_q, resp_vld_d;
    logic       resp_own_q, resp_own_d;

    // Byte-offset bits and address bits above the SRAM range are never decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{d_addr[31:ADDR_W+2], d_addr[1:0],
                                i_addr[31:ADDR_W+2], i_addr[1:0]};

    always_comb begin
        d_gnt      = 1'b0;
        i_gnt      = 1'b0;
        wait_cnt_d = 4'd0;

        // A starved fetch overrides the fixed D priority.
        if (i_req && (wait_cnt_q == MaxWait)) begin
            i_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else if (i_req) begin
            i_gnt = 1'b1;
        end

        sram_en    = d_gnt | i_gnt;
        sram_wen   = d_gnt ? d_wen : 4'b0000;
        sram_addr  = d_gnt ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
        sram_wdata = d_wdata;

        if (i_req && !i_gnt) begin
            wait_cnt_d = (wait_cnt_q >= MaxWait) ? MaxWait : wait_cnt_q + 4'd1;
        end

        resp_vld_d = sram_en && (sram_wen == 4'b0000);
        resp_own_d = i_gnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
            resp_vld_q <= 1'b0;
            resp_own_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            resp_vld_q <= resp_vld_d;
            resp_own_q <= resp_own_d;
        end
    end

    assign d_rvalid = resp_vld_q && !resp_own_q;
    assign i_rvalid = resp_vld_q && resp_own_q;
    assign d_rdata  = sram_rdata;
    assign i_rdata  = sram_rdata;

endmodule
